conv_layer_sched: RTL and testbench

- Sequences one convolution layer over the shared single-kernel conv engine. Each output channel gets one pass: fetch the kernel, clear and run the engine, then hand the finished ofmap to writeback.
- Sits between the top-level layer controller (start/done), the weight buffer (request/ready handshake), the conv engine (conv_rst/conv_en/conv_done) and the ofmap writeback unit (valid/ready).

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_sched_watchdog.sv | 39 +++
 rtl/conv_layer_sched.sv | 173 +++++++++++++++++
 tb/tb_conv_layer_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and defaults for the convolution layer scheduler.
//   conv_sched_state_t - scheduler FSM states
//   MAX_KERNELS_DEF    - default maximum output channels per layer
//   TIMEOUT_CYCLES_DEF - default conv_done watchdog limit
package conv_pkg;

  localparam int unsigned MAX_KERNELS_DEF    = 64;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 300000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WLOAD,
    CLEAR,
    RUN,
    WB,
    FINISH
  } conv_sched_state_t;

endpackage

// File: rtl/conv_sched_watchdog.sv
// conv_sched_watchdog: 32-bit cycle counter that bounds the engine run time.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   clear      - zero the counter (asserted the cycle before RUN is entered)
//   run        - count this cycle (scheduler is in RUN)
//   expired    - this RUN cycle is cycle number TIMEOUT_CYCLES
module conv_sched_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 300000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // cnt_q holds the number of RUN cycles already completed.
  assign expired = run && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: sequences one convolution layer over the shared conv
// engine, one pass per output channel: fetch kernel, clear engine, run,
// hand the ofmap to writeback.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start, abort      - layer start pulse (IDLE only), synchronous abort
//   cfg_num_kernels   - channels in this layer, clamped to MAX_KERNELS
//   busy, layer_done  - not IDLE, one-cycle completion pulse
//   wt_req_*          - weight fetch request handshake and kernel index
//   wt_loaded         - weights stable on the engine input
//   conv_rst/en/done  - engine clear, enable, done level
//   wb_valid/ready/ch - ofmap writeback handshake and channel
//   err               - sticky watchdog timeout flag
// Optional feature: define CONV_SCHED_TIMEOUT_EN to enable the RUN
// watchdog (TIMEOUT_CYCLES); otherwise err is tied 0.
module conv_layer_sched
  import conv_pkg::*;
#(
  parameter int unsigned MAX_KERNELS    = MAX_KERNELS_DEF,
  parameter int unsigned CH_W           = $clog2(MAX_KERNELS),
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [CH_W:0]   cfg_num_kernels,
  output logic            busy,
  output logic            layer_done,
  output logic            wt_req_valid,
  input  logic            wt_req_ready,
  output logic [CH_W-1:0] wt_req_idx,
  input  logic            wt_loaded,
  output logic            conv_rst,
  output logic            conv_en,
  input  logic            conv_done,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [CH_W-1:0] wb_ch,
  output logic            err
);

  localparam logic [CH_W:0] MAX_K = (CH_W + 1)'(MAX_KERNELS);

  conv_sched_state_t state_q, state_d;
  logic [CH_W:0]     n_k_q, n_k_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              rst_pulse_q, rst_pulse_d;
  logic              done_q, done_d;
  logic [CH_W:0]     n_k_clamped;
  logic              last_ch;
  logic              timeout;

  assign n_k_clamped = (cfg_num_kernels > MAX_K) ? MAX_K : cfg_num_kernels;
  assign last_ch     = ({1'b0, ch_q} + 1'b1) == n_k_q;

  always_comb begin
    state_d     = state_q;
    n_k_d       = n_k_q;
    ch_d        = ch_q;
    rst_pulse_d = 1'b0;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      // leave the engine clean if it was interrupted mid-run
      rst_pulse_d = (state_q == RUN);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_k_d   = n_k_clamped;
            ch_d    = '0;
            state_d = (n_k_clamped == '0) ? FINISH : FETCH;
          end
        end
        FETCH:  if (wt_req_ready) state_d = WLOAD;
        WLOAD:  if (wt_loaded) state_d = CLEAR;
        CLEAR:  state_d = RUN;
        RUN: begin
          if (conv_done) begin
            state_d = WB;
          end else if (timeout) begin
            rst_pulse_d = 1'b1;
            state_d     = FINISH;
          end
        end
        WB: begin
          if (wb_ready) begin
            if (last_ch) begin
              state_d = FINISH;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
        FINISH: begin
          // layer_done is registered, so it shows on the cycle after FINISH
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      n_k_q       <= '0;
      ch_q        <= '0;
      rst_pulse_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_k_q       <= n_k_d;
      ch_q        <= ch_d;
      rst_pulse_q <= rst_pulse_d;
      done_q      <= done_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign layer_done   = done_q;
  assign wt_req_valid = (state_q == FETCH);
  assign wt_req_idx   = wt_req_valid ? ch_q : '0;
  assign conv_rst     = (state_q == CLEAR) || rst_pulse_q;
  assign conv_en      = (state_q == RUN);
  assign wb_valid     = (state_q == WB);
  assign wb_ch        = wb_valid ? ch_q : '0;

`ifdef CONV_SCHED_TIMEOUT_EN
  logic err_q, err_d;

  conv_sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == CLEAR),
    .run    (state_q == RUN),
    .expired(timeout)
  );

  always_comb begin
    err_d = err_q;
    if (!abort) begin
      if (state_q == IDLE && start) begin
        err_d = 1'b0;
      end
      if (state_q == RUN && !conv_done && timeout) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: self-checking bench for conv_layer_sched. A negedge
// responder plays weight buffer, engine and writeback unit with
// configurable delays and logs every handshake; each test compares the
// logs against the expected channel sequence for the layer.
module tb_conv_layer_sched;

  localparam int unsigned MAXK = 64;
  localparam int unsigned CHW  = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [CHW:0]   cfg_num_kernels = '0;
  logic           busy, layer_done, wt_req_valid, conv_rst, conv_en, wb_valid, err;
  logic           wt_req_ready = 1'b0;
  logic           wt_loaded = 1'b0;
  logic           conv_done = 1'b0;
  logic           wb_ready = 1'b0;
  logic [CHW-1:0] wt_req_idx, wb_ch;

  conv_layer_sched #(
    .MAX_KERNELS   (MAXK),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_num_kernels(cfg_num_kernels),
    .busy           (busy),
    .layer_done     (layer_done),
    .wt_req_valid   (wt_req_valid),
    .wt_req_ready   (wt_req_ready),
    .wt_req_idx     (wt_req_idx),
    .wt_loaded      (wt_loaded),
    .conv_rst       (conv_rst),
    .conv_en        (conv_en),
    .conv_done      (conv_done),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_ch          (wb_ch),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // environment knobs
  int wt_delay = 0, wb_delay = 0, load_delay = 0, run_len = 10;
  bit wb_hold = 0;

  // environment state and logs
  int q_wt[$];
  int q_wb[$];
  int rst_cycles = 0, done_cycles = 0, en_cycles = 0, wtv_cycles = 0, wbv_cycles = 0, proto_err = 0;
  int wt_cnt = 0, wb_cnt = 0, load_cnt = 0, run_cnt = 0, pw_idx = 0, pb_ch = 0;
  bit load_pend = 0, pw_v = 0, pw_hs = 0, pb_v = 0, pb_hs = 0, prev_done = 0;

  always @(negedge clk) begin
    if (reset) begin
      wt_req_ready = 0; wt_loaded = 0; conv_done = 0; wb_ready = 0;
      load_pend = 0; run_cnt = 0; pw_v = 0; pw_hs = 0; pb_v = 0; pb_hs = 0;
      wt_cnt = 0; wb_cnt = 0; prev_done = 0;
    end else begin
      // engine: done after run_len enabled cycles, cleared by conv_rst
      if (conv_rst && conv_en) proto_err++;
      if (conv_rst) begin
        run_cnt = 0; conv_done = 0; rst_cycles++;
      end else if (conv_en) begin
        run_cnt++; en_cycles++;
        conv_done = (run_cnt >= run_len);
      end
      // weight buffer
      wt_loaded = 0;
      if (load_pend) begin
        if (load_cnt == 0) begin wt_loaded = 1; load_pend = 0; end
        else load_cnt--;
      end
      if (wt_req_valid) begin
        if (pw_v && !pw_hs && int'(wt_req_idx) != pw_idx) proto_err++;
        wt_req_ready = (wt_cnt >= wt_delay);
        wt_cnt++;
        wtv_cycles++;
        pw_hs = wt_req_ready;
        if (wt_req_ready) begin
          q_wt.push_back(int'(wt_req_idx));
          wt_cnt = 0; load_pend = 1; load_cnt = load_delay;
        end
      end else begin
        if (pw_v && !pw_hs) proto_err++;
        wt_req_ready = 0; pw_hs = 0; wt_cnt = 0;
      end
      pw_v = wt_req_valid; pw_idx = int'(wt_req_idx);
      // writeback unit
      if (wb_valid) begin
        if (pb_v && !pb_hs && int'(wb_ch) != pb_ch) proto_err++;
        if (conv_en) proto_err++;
        wb_ready = wb_hold ? 1'b1 : (wb_cnt >= wb_delay);
        wb_cnt++;
        wbv_cycles++;
        pb_hs = wb_ready;
        if (wb_ready) begin q_wb.push_back(int'(wb_ch)); wb_cnt = 0; end
      end else begin
        if (pb_v && !pb_hs) proto_err++;
        wb_ready = wb_hold; pb_hs = 0; wb_cnt = 0;
      end
      pb_v = wb_valid; pb_ch = int'(wb_ch);
      if (layer_done) begin
        done_cycles++;
        if (prev_done) proto_err++;
      end
      prev_done = layer_done;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout simulation did not finish, got stuck, required completion");
    $fatal(1);
  end

  // reference: channels actually processed for a configuration
  function automatic int model_channels(input int cfg);
    return (cfg > int'(MAXK)) ? int'(MAXK) : cfg;
  endfunction

  task automatic clear_mon();
    q_wt.delete(); q_wb.delete();
    rst_cycles = 0; done_cycles = 0; en_cycles = 0;
    wtv_cycles = 0; wbv_cycles = 0; proto_err = 0;
  endtask

  task automatic start_layer(input int cfg);
    @(negedge clk);
    cfg_num_kernels = (CHW + 1)'(cfg);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    while (layer_done !== 1'b1 && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, layer_done, wt_req_valid, wt_req_idx, conv_rst, conv_en, wb_valid, wb_ch, err} !== '0)
      $display("FAIL reset_outputs got %b required all zero",
               {busy, layer_done, wt_req_valid, wt_req_idx, conv_rst, conv_en, wb_valid, wb_ch, err});
    else n_pass++;
    reset = 0;
    // asynchronous reset mid-run
    start_layer(2);
    n = 0;
    while (conv_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (conv_en !== 1'b1) $display("FAIL reset_mid_reach_run got conv_en=%b required 1", conv_en);
    else n_pass++;
    #2 reset = 1;
    #1;
    n_checks++;
    if ({busy, layer_done, wt_req_valid, conv_rst, conv_en, wb_valid, err} !== '0)
      $display("FAIL reset_mid_outputs got %b required 0000000",
               {busy, layer_done, wt_req_valid, conv_rst, conv_en, wb_valid, err});
    else n_pass++;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic test_nominal();
    int lat;
    wt_delay = 0; wb_delay = 0; load_delay = 0; run_len = 10; wb_hold = 0;
    clear_mon();
    start_layer(3);
    wait_done(500, lat);
    n_checks++;
    if (layer_done !== 1'b1) $display("FAIL nominal_done got timeout required layer_done");
    else n_pass++;
    // per channel FETCH1 + WLOAD1 + CLEAR1 + RUN10 + WB1, then FINISH
    n_checks++;
    if (lat !== 3 * 14 + 1) $display("FAIL nominal_latency got %0d required %0d", lat, 3 * 14 + 1);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL nominal_busy_at_done got %b required 0", busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL nominal_busy_after got %b required 0", busy);
    else n_pass++;
    n_checks++;
    if (q_wt.size() != 3 || q_wb.size() != 3)
      $display("FAIL nominal_counts got wt=%0d wb=%0d required 3/3", q_wt.size(), q_wb.size());
    else n_pass++;
    for (int i = 0; i < q_wt.size() && i < q_wb.size(); i++) begin
      n_checks++;
      if (q_wt[i] != i || q_wb[i] != i)
        $display("FAIL nominal_seq[%0d] got wt=%0d wb=%0d required %0d", i, q_wt[i], q_wb[i], i);
      else n_pass++;
    end
    n_checks++;
    if (rst_cycles != 3 || done_cycles != 1 || en_cycles != 30 || proto_err != 0)
      $display("FAIL nominal_stats got rst=%0d done=%0d en=%0d proto=%0d required 3/1/30/0",
               rst_cycles, done_cycles, en_cycles, proto_err);
    else n_pass++;
  endtask

  task automatic test_zero();
    clear_mon();
    start_layer(0);
    n_checks++;
    if (layer_done !== 1'b0) $display("FAIL zero_done_early got %b required 0", layer_done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (layer_done !== 1'b1) $display("FAIL zero_done_at_2 got %b required 1", layer_done);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wtv_cycles != 0 || en_cycles != 0 || wbv_cycles != 0 || done_cycles != 1)
      $display("FAIL zero_activity got wtv=%0d en=%0d wbv=%0d done=%0d required 0/0/0/1",
               wtv_cycles, en_cycles, wbv_cycles, done_cycles);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    wt_delay = 5; wb_delay = 7; load_delay = 0; run_len = 4; wb_hold = 0;
    clear_mon();
    start_layer(2);
    wait_done(500, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cycles != 1) $display("FAIL bp_done got %0d required 1", done_cycles);
    else n_pass++;
    n_checks++;
    if (wtv_cycles != 12 || wbv_cycles != 16)
      $display("FAIL bp_valid_cycles got wtv=%0d wbv=%0d required 12/16", wtv_cycles, wbv_cycles);
    else n_pass++;
    n_checks++;
    if (proto_err != 0) $display("FAIL bp_stability got %0d violations required 0", proto_err);
    else n_pass++;
    n_checks++;
    if (q_wt.size() != 2 || q_wb.size() != 2 || q_wt[1] != 1 || q_wb[1] != 1)
      $display("FAIL bp_seq got wt=%0d wb=%0d entries required 0,1", q_wt.size(), q_wb.size());
    else n_pass++;
    wt_delay = 0; wb_delay = 0;
  endtask

  task automatic test_abort();
    int n, lat;
    wt_delay = 0; wb_delay = 0; load_delay = 1; run_len = 10; wb_hold = 0;
    clear_mon();
    start_layer(4);
    n = 0;
    while (!(conv_en === 1'b1 && q_wt.size() == 2) && n < 300) begin @(negedge clk); n++; end
    n_checks++;
    if (conv_en !== 1'b1) $display("FAIL abort_reach_run1 got conv_en=%b required 1", conv_en);
    else n_pass++;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    n_checks++;
    if ({busy, conv_en, wt_req_valid, wb_valid, layer_done, conv_rst} !== 6'b000001)
      $display("FAIL abort_next_cycle got %b required 000001",
               {busy, conv_en, wt_req_valid, wb_valid, layer_done, conv_rst});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (conv_rst !== 1'b0) $display("FAIL abort_rst_width got %b required 0", conv_rst);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cycles != 0 || rst_cycles != 3 || busy !== 1'b0)
      $display("FAIL abort_aftermath got done=%0d rst=%0d busy=%b required 0/3/0",
               done_cycles, rst_cycles, busy);
    else n_pass++;
    clear_mon();
    start_layer(2);
    wait_done(300, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cycles != 1 || q_wt.size() != 2 || q_wb.size() != 2 || q_wt[0] != 0 || q_wb[1] != 1)
      $display("FAIL abort_restart got done=%0d wt=%0d wb=%0d required 1/2/2 from ch0",
               done_cycles, q_wt.size(), q_wb.size());
    else n_pass++;
  endtask

  task automatic test_start_busy_clamp();
    int n, lat, exp_n;
    wt_delay = 0; wb_delay = 0; load_delay = 0; run_len = 3; wb_hold = 1;
    clear_mon();
    start_layer(2);
    n = 0;
    while (q_wt.size() < 1 && n < 50) begin @(negedge clk); n++; end
    cfg_num_kernels = 7'd5;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(300, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_wt.size() != 2 || q_wb.size() != 2 || done_cycles != 1)
      $display("FAIL busy_start got wt=%0d wb=%0d done=%0d required 2/2/1",
               q_wt.size(), q_wb.size(), done_cycles);
    else n_pass++;
    exp_n = model_channels(int'(MAXK) + 5);
    clear_mon();
    start_layer(int'(MAXK) + 5);
    wait_done(MAXK * 20, lat);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_wt.size() != exp_n || q_wb.size() != exp_n || done_cycles != 1)
      $display("FAIL clamp_count got wt=%0d wb=%0d done=%0d required %0d/%0d/1",
               q_wt.size(), q_wb.size(), done_cycles, exp_n, exp_n);
    else n_pass++;
    n = 0;
    for (int i = 0; i < q_wt.size() && i < q_wb.size(); i++)
      if (q_wt[i] != i || q_wb[i] != i) n++;
    n_checks++;
    if (n != 0) $display("FAIL clamp_seq got %0d out-of-order entries required 0", n);
    else n_pass++;
    wb_hold = 0;
  endtask

  task automatic test_random();
    int cfg, exp_n, lat, bad;
    for (int t = 0; t < 6; t++) begin
      cfg        = int'($urandom_range(1, 6));
      wt_delay   = int'($urandom_range(0, 3));
      wb_delay   = int'($urandom_range(0, 3));
      load_delay = int'($urandom_range(0, 3));
      run_len    = int'($urandom_range(1, 8));
      wb_hold    = 1'($urandom_range(0, 1));
      exp_n      = model_channels(cfg);
      clear_mon();
      start_layer(cfg);
      wait_done(1000, lat);
      repeat (2) @(negedge clk);
      bad = 0;
      for (int i = 0; i < q_wt.size() && i < q_wb.size(); i++)
        if (q_wt[i] != i || q_wb[i] != i) bad++;
      n_checks++;
      if (q_wt.size() != exp_n || q_wb.size() != exp_n || bad != 0)
        $display("FAIL random[%0d]_seq got wt=%0d wb=%0d bad=%0d required %0d channels in order",
                 t, q_wt.size(), q_wb.size(), bad, exp_n);
      else n_pass++;
      n_checks++;
      if (rst_cycles != exp_n || en_cycles != exp_n * run_len || done_cycles != 1 || proto_err != 0)
        $display("FAIL random[%0d]_stats got rst=%0d en=%0d done=%0d proto=%0d required %0d/%0d/1/0",
                 t, rst_cycles, en_cycles, done_cycles, proto_err, exp_n, exp_n * run_len);
      else n_pass++;
    end
    wb_hold = 0;
  endtask

`ifdef CONV_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n, lat;
    wt_delay = 0; wb_delay = 0; load_delay = 0; run_len = 1000000; wb_hold = 0;
    clear_mon();
    start_layer(1);
    n = 0;
    while (conv_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (conv_en === 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (n != 20) $display("FAIL timeout_run_cycles got %0d required 20", n);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1 || conv_rst !== 1'b1)
      $display("FAIL timeout_err_rst got err=%b conv_rst=%b required 1/1", err, conv_rst);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (layer_done !== 1'b1) $display("FAIL timeout_done got %b required 1", layer_done);
    else n_pass++;
    run_len = 2;
    start_layer(1);
    n_checks++;
    if (err !== 1'b0) $display("FAIL timeout_err_clear got %b required 0", err);
    else n_pass++;
    wait_done(200, lat);
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_zero();
    test_backpressure();
    test_abort();
    test_start_busy_clamp();
    test_random();
`ifdef CONV_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
